useq_control: RTL and testbench
===============================

// Module: useq_control
// PURPOSE
//  Parametrised microcoded sequencer: next-generation control unit driving datapath control bits.
//  Adds condition-select with polarity, call/return stack, loop counter, halt/start, and a microcode write port.
//  Sits between the datapath (which supplies condition flags) and the top level (which loads microcode and starts it).
// PARAMETERS
//  P_LOG_MEMSIZE     5  log2 of microcode depth; also width of upc, addr field and loop counter
//  P_NUM_D_CTRLBITS  8  datapath control bits per word
//  P_NUM_COND        4  number of condition inputs (>=2, power of 2); LP_CSEL_W = log2(P_NUM_COND)
//  P_STACK_DEPTH     4  return-stack entries (>=1)
//  LP_WORDWIDTH = P_NUM_D_CTRLBITS+3+LP_CSEL_W+1+P_LOG_MEMSIZE (19 at defaults)
// PORTS
//  clk        in   1              clock; all state updates on rising edge
//  rst        in   1              asynchronous, active-low reset
//  start      in   1              pulse: leave HALTED state
//  cond       in   P_NUM_COND     datapath condition flags, sampled combinationally
//  prog_we    in   1              microcode write enable
//  prog_addr  in   P_LOG_MEMSIZE  microcode write address
//  prog_data  in   LP_WORDWIDTH   microcode write data
//  dp_ctrl    out  P_NUM_D_CTRLBITS  datapath control of current word; 0 while halted
//  upc        out  P_LOG_MEMSIZE  current micro-PC
//  halted     out  1              sequencer halted
//  err        out  1              sticky stack fault flag
// BEHAVIOUR
//  Word fields MSB->LSB: dp[D] | op[3] | csel[LP_CSEL_W] | pol[1] | addr[P_LOG_MEMSIZE].
//  Memory: async read at upc; sync write on prog_we (any state); write to current upc seen next cycle. Not reset.
//  Reset (rst=0): upc=0, sp=0, cnt=0, halted=1, err=0. dp_ctrl therefore 0.
//  t = cond[csel]^pol. Opcodes, evaluated each cycle while running (halted=0); default next = upc+1 (wraps max->0):
//   0 NEXT : upc<=upc+1
//   1 JMP  : upc<=addr
//   2 JC   : upc<= t ? addr : upc+1
//   3 CALL : stack full -> FAULT; else push upc+1, sp++, upc<=addr
//   4 RET  : stack empty -> FAULT; else sp--, upc<=popped value
//   5 LDCNT: cnt<=addr, upc<=upc+1
//   6 DJNZ : cnt!=0 -> cnt<=cnt-1, upc<=addr; cnt==0 -> upc<=upc+1 (LDCNT N => body runs N+1 times)
//   7 HALT : halted<=1, upc<=upc+1
//  FAULT: halted<=1, err<=1, upc/sp/cnt unchanged (upc points at faulting word).
//  dp_ctrl = halted ? 0 : dp field; the word's dp bits are output in the cycle it executes, including HALT/faulting words.
//  States: HALTED (halted=1) / RUN (halted=0). HALTED: no opcode evaluated, upc/sp/cnt held.
//  start in HALTED with err=0: halted<=0, resume at held upc (stack, cnt kept).
//  start in HALTED with err=1: err<=0, sp<=0, upc<=0, halted<=0 (clean restart).
//  start while RUN: ignored. prog_we and start in same cycle: both take effect.
//  Latency: start -> first word on dp_ctrl the next cycle; control-flow change visible on upc one cycle after the word.
//  Reset mid-run: immediate async return to reset state; memory contents retained.
// TESTING
//  Load [0]:NEXT dp=0x11,[1]:HALT dp=0x22; start -> dp_ctrl 0x11,0x22, then 0; halted=1, upc=2.
//  JC csel=2 pol=0 addr=9 at 0: cond=4'b0100 -> upc 9; cond=0 -> upc 1; pol=1 inverts both outcomes.
//  CALL 8 at 3, RET at 8: upc 3->8->4, sp 0->1->0; nest 4 CALLs ok, 5th -> err=1, halted=1, upc=faulting addr.
//  LDCNT 2 at 0, body at 1, DJNZ 1 at 2, HALT at 3: body executes 3 times, halts with cnt=0, upc=4.
//  RET at 0 with empty stack -> err=1; start -> err=0, upc=0, sp=0; rst low mid-loop -> halted=1, upc=0, dp_ctrl=0.
//  Word at upc=31 NEXT: upc wraps to 0; prog_we to current upc while running -> new dp_ctrl next cycle only.

Source files
------------

// File: rtl/useq_control_if.sv
// Sequencer bus: start/condition inputs, microcode write port and status outputs.
interface useq_control_if #(
    parameter int unsigned P_LOG_MEMSIZE    = 5,
    parameter int unsigned P_NUM_D_CTRLBITS = 8,
    parameter int unsigned P_NUM_COND       = 4
);
    localparam int unsigned LP_CSEL_W    = $clog2(P_NUM_COND);
    localparam int unsigned LP_WORDWIDTH = P_NUM_D_CTRLBITS + 3 + LP_CSEL_W + 1 + P_LOG_MEMSIZE;

    logic                        start;
    logic [P_NUM_COND-1:0]       cond;
    logic                        prog_we;
    logic [P_LOG_MEMSIZE-1:0]    prog_addr;
    logic [LP_WORDWIDTH-1:0]     prog_data;
    logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl;
    logic [P_LOG_MEMSIZE-1:0]    upc;
    logic                        halted;
    logic                        err;

    modport master (
        output start, cond, prog_we, prog_addr, prog_data,
        input  dp_ctrl, upc, halted, err
    );

    modport slave (
        input  start, cond, prog_we, prog_addr, prog_data,
        output dp_ctrl, upc, halted, err
    );
endinterface

// File: rtl/useq_control.sv
// Microcoded sequencer with condition select, return stack, loop counter and halt/start.
module useq_control #(
    parameter int unsigned P_LOG_MEMSIZE    = 5,
    parameter int unsigned P_NUM_D_CTRLBITS = 8,
    parameter int unsigned P_NUM_COND       = 4,
    parameter int unsigned P_STACK_DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    useq_control_if.slave bus
);
    localparam int unsigned LP_CSEL_W    = $clog2(P_NUM_COND);
    localparam int unsigned LP_WORDWIDTH = P_NUM_D_CTRLBITS + 3 + LP_CSEL_W + 1 + P_LOG_MEMSIZE;
    localparam int unsigned LP_MEMDEPTH  = 2 ** P_LOG_MEMSIZE;
    localparam int unsigned LP_SP_W      = $clog2(P_STACK_DEPTH + 1);
    localparam int unsigned LP_IDX_W     = (P_STACK_DEPTH > 1) ? $clog2(P_STACK_DEPTH) : 1;
    localparam int unsigned LP_OP_LSB    = P_LOG_MEMSIZE + 1 + LP_CSEL_W;

    typedef enum logic [2:0] {
        OpNext  = 3'd0,
        OpJmp   = 3'd1,
        OpJc    = 3'd2,
        OpCall  = 3'd3,
        OpRet   = 3'd4,
        OpLdcnt = 3'd5,
        OpDjnz  = 3'd6,
        OpHalt  = 3'd7
    } op_e;

    typedef enum logic {StHalted = 1'b0, StRun = 1'b1} state_e;

    logic [LP_WORDWIDTH-1:0]  r_mem   [LP_MEMDEPTH];
    logic [P_LOG_MEMSIZE-1:0] r_stack [P_STACK_DEPTH];

    state_e                   r_state, w_state_d;
    logic [P_LOG_MEMSIZE-1:0] r_upc, w_upc_d;
    logic [P_LOG_MEMSIZE-1:0] r_cnt, w_cnt_d;
    logic [LP_SP_W-1:0]       r_sp, w_sp_d;
    logic                     r_err, w_err_d;
    logic                     w_push;

    logic [LP_WORDWIDTH-1:0]     w_word;
    logic [P_NUM_D_CTRLBITS-1:0] w_dp;
    op_e                         w_op;
    logic [LP_CSEL_W-1:0]        w_csel;
    logic                        w_pol;
    logic [P_LOG_MEMSIZE-1:0]    w_addr;
    logic                        w_taken;
    logic [P_LOG_MEMSIZE-1:0]    w_upc_inc;
    logic                        w_full;
    logic                        w_empty;
    logic [LP_IDX_W-1:0]         w_push_idx;
    logic [LP_IDX_W-1:0]         w_pop_idx;

    // Decode the word at the current micro-PC (asynchronous read).
    assign w_word     = r_mem[r_upc];
    assign w_dp       = w_word[LP_WORDWIDTH-1 -: P_NUM_D_CTRLBITS];
    assign w_op       = op_e'(w_word[LP_OP_LSB +: 3]);
    assign w_csel     = w_word[P_LOG_MEMSIZE+1 +: LP_CSEL_W];
    assign w_pol      = w_word[P_LOG_MEMSIZE];
    assign w_addr     = w_word[P_LOG_MEMSIZE-1:0];
    assign w_taken    = bus.cond[w_csel] ^ w_pol;
    assign w_upc_inc  = r_upc + P_LOG_MEMSIZE'(1);
    assign w_full     = (r_sp == LP_SP_W'(P_STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = LP_IDX_W'(r_sp);
    assign w_pop_idx  = LP_IDX_W'(r_sp - LP_SP_W'(1));

    // Next-state logic: start handling while halted, opcode execution while running.
    always_comb begin
        w_state_d = r_state;
        w_upc_d   = r_upc;
        w_cnt_d   = r_cnt;
        w_sp_d    = r_sp;
        w_err_d   = r_err;
        w_push    = 1'b0;
        unique case (r_state)
            StHalted: begin
                if (bus.start) begin
                    w_state_d = StRun;
                    // A faulted machine restarts from a clean slate.
                    if (r_err) begin
                        w_err_d = 1'b0;
                        w_sp_d  = '0;
                        w_upc_d = '0;
                    end
                end
            end
            StRun: begin
                w_upc_d = w_upc_inc;
                unique case (w_op)
                    OpNext: ;
                    OpJmp:  w_upc_d = w_addr;
                    OpJc:   if (w_taken) w_upc_d = w_addr;
                    OpCall: begin
                        if (w_full) begin
                            w_state_d = StHalted;
                            w_err_d   = 1'b1;
                            w_upc_d   = r_upc;
                        end else begin
                            w_push  = 1'b1;
                            w_sp_d  = r_sp + LP_SP_W'(1);
                            w_upc_d = w_addr;
                        end
                    end
                    OpRet: begin
                        if (w_empty) begin
                            w_state_d = StHalted;
                            w_err_d   = 1'b1;
                            w_upc_d   = r_upc;
                        end else begin
                            w_sp_d  = r_sp - LP_SP_W'(1);
                            w_upc_d = r_stack[w_pop_idx];
                        end
                    end
                    OpLdcnt: w_cnt_d = w_addr;
                    OpDjnz: begin
                        if (r_cnt != '0) begin
                            w_cnt_d = r_cnt - P_LOG_MEMSIZE'(1);
                            w_upc_d = w_addr;
                        end
                    end
                    OpHalt: w_state_d = StHalted;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StHalted;
            r_upc   <= '0;
            r_cnt   <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_upc   <= w_upc_d;
            r_cnt   <= w_cnt_d;
            r_sp    <= w_sp_d;
            r_err   <= w_err_d;
        end
    end

    // Microcode store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Return-address stack storage; only the pointer is reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_upc_inc;
        end
    end

    assign bus.dp_ctrl = (r_state == StHalted) ? '0 : w_dp;
    assign bus.upc     = r_upc;
    assign bus.halted  = (r_state == StHalted);
    assign bus.err     = r_err;
endmodule

// File: tb/tb_useq_control.sv
// Self-checking bench for useq_control: directed scenarios plus randomized run vs a reference model.
module tb_useq_control;
    localparam int unsigned LM = 5;
    localparam int unsigned D  = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned W  = 19;
    localparam int unsigned MD = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    useq_control_if #(.P_LOG_MEMSIZE(LM), .P_NUM_D_CTRLBITS(D), .P_NUM_COND(NC)) bus ();

    useq_control #(
        .P_LOG_MEMSIZE(LM),
        .P_NUM_D_CTRLBITS(D),
        .P_NUM_COND(NC),
        .P_STACK_DEPTH(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state only, stack kept as a queue.
    logic [W-1:0] m_mem [MD];
    int           m_upc = 0;
    int           m_cnt = 0;
    bit           m_halted = 1'b1;
    bit           m_err = 1'b0;
    int           m_stack [$];
    logic [W-1:0] m_w;
    int           m_op, m_addr, m_nxt;
    bit           m_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_upc = 0; m_cnt = 0; m_halted = 1'b1; m_err = 1'b0;
            m_stack.delete();
        end else begin
            m_w    = m_mem[m_upc];
            m_op   = int'(m_w[10:8]);
            m_addr = int'(m_w[4:0]);
            m_t    = bus.cond[m_w[7:6]] ^ m_w[5];
            m_nxt  = (m_upc + 1) % MD;
            if (m_halted) begin
                if (bus.start) begin
                    m_halted = 1'b0;
                    if (m_err) begin
                        m_err = 1'b0; m_upc = 0;
                        m_stack.delete();
                    end
                end
            end else begin
                case (m_op)
                    0: m_upc = m_nxt;
                    1: m_upc = m_addr;
                    2: m_upc = m_t ? m_addr : m_nxt;
                    3: if (m_stack.size() == SD) begin
                           m_halted = 1'b1; m_err = 1'b1;
                       end else begin
                           m_stack.push_back(m_nxt); m_upc = m_addr;
                       end
                    4: if (m_stack.size() == 0) begin
                           m_halted = 1'b1; m_err = 1'b1;
                       end else begin
                           m_upc = m_stack.pop_back();
                       end
                    5: begin m_cnt = m_addr; m_upc = m_nxt; end
                    6: if (m_cnt != 0) begin
                           m_cnt = m_cnt - 1; m_upc = m_addr;
                       end else begin
                           m_upc = m_nxt;
                       end
                    default: begin m_halted = 1'b1; m_upc = m_nxt; end
                endcase
            end
            if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_data;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] cur;
        cur = m_mem[m_upc];
        chk("halted", int'(bus.halted), int'(m_halted));
        chk("err", int'(bus.err), int'(m_err));
        chk("upc", int'(bus.upc), m_upc);
        chk("dp_ctrl", int'(bus.dp_ctrl), m_halted ? 0 : int'(cur[18:11]));
    end

    function automatic logic [W-1:0] mk(input int dp, input int op, input int csel,
                                        input int pol, input int addr);
        mk = {dp[7:0], op[2:0], csel[1:0], pol[0], addr[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input logic [W-1:0] d);
        bus.prog_addr = a[4:0];
        bus.prog_data = d;
        bus.prog_we   = 1'b1;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !bus.halted; i++) tick();
        chk("halt_reached", int'(bus.halted), 1);
    endtask

    task automatic run_jc(input int pol, input logic [3:0] c, input int exp);
        prog(0, mk(0, 2, 2, pol, 9));
        hard_reset();
        bus.cond = c;
        pulse_start();
        tick();
        chk("jc_target", int'(bus.upc), exp);
    endtask

    initial begin
        int body;
        logic [31:0] r;
        bit do_rst;
        bus.start = 1'b0; bus.cond = '0; bus.prog_we = 1'b0;
        bus.prog_addr = '0; bus.prog_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_halted", int'(bus.halted), 1);
        chk("rst_upc", int'(bus.upc), 0);
        chk("rst_dp", int'(bus.dp_ctrl), 0);
        chk("rst_err", int'(bus.err), 0);
        for (int i = 0; i < int'(MD); i++) prog(i, '0);

        // NEXT then HALT
        prog(0, mk(8'h11, 0, 0, 0, 0));
        prog(1, mk(8'h22, 7, 0, 0, 0));
        pulse_start();
        chk("s1_dp0", int'(bus.dp_ctrl), 8'h11);
        tick();
        chk("s1_dp1", int'(bus.dp_ctrl), 8'h22);
        tick();
        chk("s1_halt", int'(bus.halted), 1);
        chk("s1_upc", int'(bus.upc), 2);
        chk("s1_dp_off", int'(bus.dp_ctrl), 0);

        // Conditional jump with both polarities
        run_jc(0, 4'b0100, 9);
        run_jc(0, 4'b1011, 1);
        run_jc(1, 4'b0100, 1);
        run_jc(1, 4'b1011, 9);

        // CALL / RET
        hard_reset();
        prog(0, '0); prog(1, '0); prog(2, '0);
        prog(3, mk(8'h33, 3, 0, 0, 8));
        prog(8, mk(8'h88, 4, 0, 0, 0));
        prog(4, mk(8'h44, 7, 0, 0, 0));
        pulse_start();
        repeat (3) tick();
        chk("call_dp", int'(bus.dp_ctrl), 8'h33);
        tick();
        chk("call_upc", int'(bus.upc), 8);
        tick();
        chk("ret_upc", int'(bus.upc), 4);

        // Stack overflow on the fifth nested CALL
        prog(0, mk(0, 1, 0, 0, 10));
        for (int i = 10; i < 15; i++) prog(i, mk(i, 3, 0, 0, i + 1));
        hard_reset();
        pulse_start();
        wait_halt(20);
        chk("ovf_err", int'(bus.err), 1);
        chk("ovf_upc", int'(bus.upc), 14);
        pulse_start();
        chk("restart_upc", int'(bus.upc), 0);
        chk("restart_err", int'(bus.err), 0);
        chk("restart_run", int'(bus.halted), 0);
        wait_halt(20);
        chk("ovf2_upc", int'(bus.upc), 14);

        // RET with empty stack
        hard_reset();
        prog(0, mk(8'h5a, 4, 0, 0, 0));
        pulse_start();
        tick();
        chk("uf_err", int'(bus.err), 1);
        chk("uf_upc", int'(bus.upc), 0);

        // Loop counter: LDCNT 2 runs the body three times
        hard_reset();
        prog(0, mk(0, 5, 0, 0, 2));
        prog(1, mk(8'h55, 0, 0, 0, 0));
        prog(2, mk(0, 6, 0, 0, 1));
        prog(3, mk(0, 7, 0, 0, 0));
        prog(4, mk(0, 6, 0, 0, 7));
        prog(5, mk(0, 7, 0, 0, 0));
        pulse_start();
        body = 0;
        for (int i = 0; i < 30 && !bus.halted; i++) begin
            if (bus.dp_ctrl == 8'h55) body++;
            tick();
        end
        chk("loop_body", body, 3);
        chk("loop_upc", int'(bus.upc), 4);
        pulse_start();
        repeat (2) tick();
        chk("cnt_zero", int'(bus.upc), 6);

        // Wrap from the last word
        hard_reset();
        prog(0, mk(8'h01, 1, 0, 0, 31));
        prog(31, mk(8'h31, 0, 0, 0, 0));
        pulse_start();
        tick();
        chk("wrap_dp", int'(bus.dp_ctrl), 8'h31);
        tick();
        chk("wrap_upc", int'(bus.upc), 0);

        // Rewrite the executing word: new bits appear next cycle only
        hard_reset();
        prog(0, mk(0, 1, 0, 0, 5));
        prog(5, mk(8'h0a, 1, 0, 0, 5));
        pulse_start();
        tick();
        bus.prog_addr = 5'd5;
        bus.prog_data = mk(8'h0b, 1, 0, 0, 5);
        bus.prog_we   = 1'b1;
        chk("wr_old", int'(bus.dp_ctrl), 8'h0a);
        tick();
        bus.prog_we   = 1'b0;
        chk("wr_new", int'(bus.dp_ctrl), 8'h0b);

        // Asynchronous reset mid-run
        rst = 1'b0;
        #1;
        chk("arst_halted", int'(bus.halted), 1);
        chk("arst_upc", int'(bus.upc), 0);
        chk("arst_dp", int'(bus.dp_ctrl), 0);
        tick();
        rst = 1'b1;

        // Randomized program, conditions, starts, writes and resets
        for (int i = 0; i < int'(MD); i++) begin
            r = $urandom;
            prog(i, r[W-1:0]);
        end
        for (int c = 0; c < 4000; c++) begin
            r = $urandom;
            bus.cond  = r[3:0];
            bus.start = (r[6:4] < 3'd3);
            do_rst    = ($urandom_range(0, 199) == 0);
            if (!do_rst && r[11:8] == 4'd0) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = r[16:12];
                r = $urandom;
                bus.prog_data = r[W-1:0];
            end else begin
                bus.prog_we = 1'b0;
            end
            if (do_rst) rst = 1'b0;
            tick();
            rst = 1'b1;
        end
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
